fishing_round_sequencer: RTL and testbench
==========================================

// Module: fishing_round_sequencer
// PURPOSE
//  Sequences one timed fishing round for the logged-in user. Sits between the access controller
//  (validOut, user_ID, gated game-start/reel buttons) and the score keeper. Generates bite events
//  from an external LFSR value, times the reel window, and accumulates the round score. At round
//  end it issues a single score write tagged with the user ID.
// PARAMETERS
//  TICK_CYCLES   50000000  clk cycles per game tick (1 s at 50 MHz); bench uses 4
//  GAME_TICKS    30        round length in ticks, 1..127
//  REEL_TICKS    2         bite window length in ticks, 1..15
//  SCORE_MAX     99        score saturation value, <=255
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous reset, active-low
//  access_valid  in   1  user logged in (access controller validOut)
//  user_id       in   3  logged-in user address 0..5
//  start_pulse   in   1  one-cycle game-start press (already gated by access controller)
//  reel_pulse    in   1  one-cycle reel press (already gated by access controller)
//  rand_val      in   8  free-running pseudo-random value from LFSR
//  state_code    out  4  current state index for the 7-seg decoder
//  time_left     out  7  remaining round ticks
//  round_score   out  8  accumulated score this round
//  bite_led      out  1  high while in BITE
//  game_over     out  1  high in DONE
//  score_wr_en   out  1  one-cycle write strobe to score keeper
//  score_user    out  3  user ID latched at round start, valid with score_wr_en
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE; all outputs, counters and the prescaler cleared to 0.
//  All outputs are registered; they reflect a transition one cycle after the triggering edge.
//  States (state_code): IDLE=0 READY=1 WAIT_BITE=2 BITE=3 SCORE=4 DONE=5.
//  Prescaler: runs only in WAIT_BITE/BITE; counts 0..TICK_CYCLES-1; tick=1 on the terminal count.
//   Cleared on round start.
//  IDLE: access_valid=1 -> READY. start_pulse ignored.
//  READY: start_pulse -> WAIT_BITE; time_left<=GAME_TICKS; round_score<=0; score_user<=user_id;
//   bite_cnt<=1+rand_val[2:0].
//  WAIT_BITE: on each tick, bite_cnt-1; when it reaches 0 -> BITE, win_cnt<=REEL_TICKS.
//   reel_pulse here (early reel) reloads bite_cnt<=1+rand_val[2:0]; no score.
//  BITE: bite_led=1. reel_pulse -> round_score<=min(round_score+1+rand_val[1:0],SCORE_MAX);
//   -> WAIT_BITE with a fresh bite_cnt. On each tick, win_cnt-1; at 0 -> WAIT_BITE (miss), no score.
//  Round timer: in WAIT_BITE/BITE each tick decrements time_left; on 1->0 -> SCORE.
//   Expiry has priority over bite/reel/miss in the same cycle; that reel is not scored.
//  SCORE: exactly one cycle with score_wr_en=1 carrying round_score and score_user; -> DONE.
//  DONE: game_over=1; outputs held. start_pulse -> new round (same init as READY->WAIT_BITE).
//  Logout: access_valid=0 in any state except IDLE -> IDLE next cycle. Round aborted: no
//   score_wr_en; round_score, time_left and bite_led cleared. Logout beats every other event.
//  Score add is 9-bit internal; saturates at SCORE_MAX and never wraps.
//  reel_pulse in IDLE/READY/SCORE/DONE is ignored.
// TESTING (bench: TICK_CYCLES=4, GAME_TICKS=5, REEL_TICKS=2)
//  1 rst low 2 clk -> state_code=0, all outputs 0; start_pulse with access_valid=0 -> stays 0.
//  2 access_valid=1, user_id=3, start_pulse, rand_val=8'h02 -> state 2, time_left=5;
//    bite_led rises after 3 ticks (12 clk).
//  3 reel_pulse in BITE with rand_val[1:0]=2 -> round_score+3, state 2, bite_led=0 next clk;
//    reel in WAIT_BITE -> bite delay restarts, score unchanged.
//  4 no reel in BITE -> bite_led low after 2 ticks, score unchanged; preload score 98 + reel
//    with rand_val[1:0]=3 -> 99.
//  5 let time_left reach 0 with reel on the same cycle -> that reel not scored; one-cycle
//    score_wr_en with score_user=3, then state 5, game_over=1; start_pulse -> state 2, time_left=5.
//  6 drop access_valid in BITE -> state 0 next clk, score_wr_en never pulses, round_score=0.

Source files
------------

// File: rtl/fishing_round_sequencer_if.sv
// Signal bundle between the access controller, the round sequencer and the score keeper.
// master drives user inputs and reads round status; slave is the sequencer side.
interface fishing_round_sequencer_if;
    logic       access_valid;
    logic [2:0] user_id;
    logic       start_pulse;
    logic       reel_pulse;
    logic [7:0] rand_val;
    logic [3:0] state_code;
    logic [6:0] time_left;
    logic [7:0] round_score;
    logic       bite_led;
    logic       game_over;
    logic       score_wr_en;
    logic [2:0] score_user;

    modport master (
        output access_valid, user_id, start_pulse, reel_pulse, rand_val,
        input  state_code, time_left, round_score, bite_led, game_over, score_wr_en, score_user
    );
    modport slave (
        input  access_valid, user_id, start_pulse, reel_pulse, rand_val,
        output state_code, time_left, round_score, bite_led, game_over, score_wr_en, score_user
    );
endinterface

// File: rtl/fishing_round_sequencer.sv
// Timed fishing round: prescaled ticks drive bite delay, reel window and round timer.
// All outputs registered (one cycle after the triggering edge); no backpressure, pulses are sampled once.
module fishing_round_sequencer #(
    parameter int TICK_CYCLES = 50000000,
    parameter int GAME_TICKS  = 30,
    parameter int REEL_TICKS  = 2,
    parameter int SCORE_MAX   = 99
) (
    input  logic                            clk,
    input  logic                            rst,
    fishing_round_sequencer_if.slave        bus
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        READY     = 4'd1,
        WAIT_BITE = 4'd2,
        BITE      = 4'd3,
        SCORE     = 4'd4,
        DONE      = 4'd5
    } state_t;

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    time_q, time_d;
    logic [7:0]    score_q, score_d;
    logic [2:0]    user_q, user_d;
    logic [3:0]    bite_cnt_q, bite_cnt_d;
    logic [3:0]    win_q, win_d;
    logic          led_q, over_q, wr_q;

    logic          in_round, tick;
    logic [3:0]    fresh_bite;
    logic [8:0]    sum;
    logic          unused_rand;

    assign in_round    = (state_q == WAIT_BITE) || (state_q == BITE);
    assign tick        = in_round && (presc_q == PW'(TICK_CYCLES - 1));
    assign fresh_bite  = 4'd1 + {1'b0, bus.rand_val[2:0]};
    assign sum         = {1'b0, score_q} + 9'd1 + {7'd0, bus.rand_val[1:0]};
    assign unused_rand = ^bus.rand_val[7:3];

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        time_d     = time_q;
        score_d    = score_q;
        user_d     = user_q;
        bite_cnt_d = bite_cnt_q;
        win_d      = win_q;

        if (in_round) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick) begin
            time_d = time_q - 7'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.access_valid) state_d = READY;
            end
            READY, DONE: begin
                if (bus.start_pulse) begin
                    state_d    = WAIT_BITE;
                    presc_d    = '0;
                    time_d     = 7'(GAME_TICKS);
                    score_d    = 8'd0;
                    user_d     = bus.user_id;
                    bite_cnt_d = fresh_bite;
                end
            end
            WAIT_BITE: begin
                if (bus.reel_pulse) begin
                    bite_cnt_d = fresh_bite;
                end else if (tick) begin
                    bite_cnt_d = bite_cnt_q - 4'd1;
                    if (bite_cnt_q == 4'd1) begin
                        state_d = BITE;
                        win_d   = 4'(REEL_TICKS);
                    end
                end
            end
            BITE: begin
                if (bus.reel_pulse) begin
                    score_d    = (sum > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : sum[7:0];
                    state_d    = WAIT_BITE;
                    bite_cnt_d = fresh_bite;
                end else if (tick) begin
                    win_d = win_q - 4'd1;
                    if (win_q == 4'd1) begin
                        state_d    = WAIT_BITE;
                        bite_cnt_d = fresh_bite;
                    end
                end
            end
            SCORE:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Round expiry overrides any bite/reel/miss decided above, including a reel score.
        if (tick && (time_q == 7'd1)) begin
            state_d = SCORE;
            score_d = score_q;
        end

        if (!bus.access_valid && (state_q != IDLE)) begin
            state_d = IDLE;
            presc_d = '0;
            time_d  = 7'd0;
            score_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            time_q     <= 7'd0;
            score_q    <= 8'd0;
            user_q     <= 3'd0;
            bite_cnt_q <= 4'd0;
            win_q      <= 4'd0;
            led_q      <= 1'b0;
            over_q     <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            time_q     <= time_d;
            score_q    <= score_d;
            user_q     <= user_d;
            bite_cnt_q <= bite_cnt_d;
            win_q      <= win_d;
            led_q      <= (state_d == BITE);
            over_q     <= (state_d == DONE);
            wr_q       <= (state_d == SCORE);
        end
    end

    assign bus.state_code  = state_q;
    assign bus.time_left   = time_q;
    assign bus.round_score = score_q;
    assign bus.bite_led    = led_q;
    assign bus.game_over   = over_q;
    assign bus.score_wr_en = wr_q;
    assign bus.score_user  = user_q;
endmodule

// File: tb/tb_fishing_round_sequencer.sv
// Directed bench: a tick-count model checks dut_a every cycle; dut_b (long round) covers score saturation.
module tb_fishing_round_sequencer;
    localparam int TICK = 4;
    localparam int GAME = 5;
    localparam int REEL = 2;
    localparam int SMAX = 99;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fishing_round_sequencer_if ia ();
    fishing_round_sequencer_if ib ();

    fishing_round_sequencer #(.TICK_CYCLES(TICK), .GAME_TICKS(GAME), .REEL_TICKS(REEL), .SCORE_MAX(SMAX))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    fishing_round_sequencer #(.TICK_CYCLES(TICK), .GAME_TICKS(127), .REEL_TICKS(REEL), .SCORE_MAX(SMAX))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;
    int wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: round progress as elapsed ticks; bite and miss as absolute tick deadlines.
    int m_st = 0, m_tl = 0, m_score = 0, m_user = 0;
    int m_te = 0, m_cyc = 0, m_bite_at = 0, m_miss_at = 0;
    bit m_wr = 0;

    always @(posedge clk) begin
        bit tk;
        int n, inc;
        if (!rst) begin
            m_st = 0; m_tl = 0; m_score = 0; m_user = 0; m_wr = 0; m_te = 0; m_cyc = 0;
        end else begin
            m_wr = 0;
            n    = 1 + int'(ia.rand_val[2:0]);
            inc  = 1 + int'(ia.rand_val[1:0]);
            if (m_st != 0 && !ia.access_valid) begin
                m_st = 0; m_score = 0; m_tl = 0;
            end else begin
                case (m_st)
                    0: if (ia.access_valid) m_st = 1;
                    1, 5: if (ia.start_pulse) begin
                        m_st = 2; m_cyc = 0; m_te = 0; m_score = 0; m_tl = GAME;
                        m_user = int'(ia.user_id); m_bite_at = n;
                    end
                    2, 3: begin
                        tk = (m_cyc % TICK) == TICK - 1;
                        m_cyc++;
                        if (tk) m_te++;
                        m_tl = GAME - m_te;
                        if (tk && m_te == GAME) begin
                            m_st = 4; m_wr = 1;
                        end else if (m_st == 2) begin
                            if (ia.reel_pulse) m_bite_at = m_te + n;
                            else if (tk && m_te == m_bite_at) begin
                                m_st = 3; m_miss_at = m_te + REEL;
                            end
                        end else begin
                            if (ia.reel_pulse) begin
                                m_score = (m_score + inc > SMAX) ? SMAX : m_score + inc;
                                m_st = 2; m_bite_at = m_te + n;
                            end else if (tk && m_te == m_miss_at) begin
                                m_st = 2; m_bite_at = m_te + n;
                            end
                        end
                    end
                    4: m_st = 5;
                    default: m_st = 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state_code", 32'(ia.state_code), 32'(m_st));
            check("time_left", 32'(ia.time_left), 32'(m_tl));
            check("round_score", 32'(ia.round_score), 32'(m_score));
            check("bite_led", 32'(ia.bite_led), 32'(m_st == 3));
            check("game_over", 32'(ia.game_over), 32'(m_st == 5));
            check("score_wr_en", 32'(ia.score_wr_en), 32'(m_wr));
            check("score_user", 32'(ia.score_user), 32'(m_user));
        end
        if (ia.score_wr_en === 1'b1) wr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_a_led(input logic want, output int k);
        k = 0;
        while (ia.bite_led !== want && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_b_led(output int k);
        k = 0;
        while (ib.bite_led !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    int k;
    int exp_b;
    logic [7:0] rb;

    initial begin
        ia.access_valid = 0; ia.user_id = 0; ia.start_pulse = 0; ia.reel_pulse = 0; ia.rand_val = 0;
        ib.access_valid = 0; ib.user_id = 0; ib.start_pulse = 0; ib.reel_pulse = 0; ib.rand_val = 0;

        // Reset and ignored start without login
        step(2);
        cmp_en = 1;
        check("rst_state", 32'(ia.state_code), 0);
        check("rst_outputs", 32'({ia.time_left, ia.round_score, ia.bite_led, ia.game_over, ia.score_wr_en, ia.score_user}), 0);
        rst = 1;
        ia.start_pulse = 1;
        step(1);
        ia.start_pulse = 0;
        check("start_no_login", 32'(ia.state_code), 0);

        // Round 1: login, start, first bite after 3 ticks
        ia.access_valid = 1; ia.user_id = 3;
        step(1);
        check("login_ready", 32'(ia.state_code), 1);
        ia.start_pulse = 1; ia.rand_val = 8'h02;
        step(1);
        ia.start_pulse = 0;
        check("start_state", 32'(ia.state_code), 2);
        check("start_time", 32'(ia.time_left), 5);
        wait_a_led(1'b1, k);
        check("bite_delay_clks", 32'(k), 12);

        // Scored reel: +3
        ia.reel_pulse = 1; ia.rand_val = 8'h02;
        step(1);
        ia.reel_pulse = 0;
        check("reel_score", 32'(ia.round_score), 3);
        check("reel_state", 32'(ia.state_code), 2);
        check("reel_led_off", 32'(ia.bite_led), 0);
        check("reel_time", 32'(ia.time_left), 2);

        // Early reel restarts bite delay with a 1-tick delay, no score
        ia.reel_pulse = 1; ia.rand_val = 8'h00;
        step(1);
        ia.reel_pulse = 0;
        check("early_reel_score", 32'(ia.round_score), 3);
        wait_a_led(1'b1, k);
        check("early_reel_delay", 32'(k), 2);

        // Reel on the expiry cycle is not scored
        step(3);
        ia.reel_pulse = 1; ia.rand_val = 8'h03;
        step(1);
        ia.reel_pulse = 0;
        check("expiry_state", 32'(ia.state_code), 4);
        check("expiry_wr", 32'(ia.score_wr_en), 1);
        check("expiry_user", 32'(ia.score_user), 3);
        check("expiry_score", 32'(ia.round_score), 3);
        step(1);
        check("done_state", 32'(ia.state_code), 5);
        check("done_over", 32'(ia.game_over), 1);
        check("done_wr_low", 32'(ia.score_wr_en), 0);
        step(3);
        check("done_held", 32'(ia.round_score), 3);

        // Round 2: restart from DONE, one reel, then a miss
        ia.start_pulse = 1; ia.rand_val = 8'h00;
        step(1);
        ia.start_pulse = 0;
        check("restart_state", 32'(ia.state_code), 2);
        check("restart_time", 32'(ia.time_left), 5);
        check("restart_score", 32'(ia.round_score), 0);
        wait_a_led(1'b1, k);
        check("r2_bite_clks", 32'(k), 4);
        ia.reel_pulse = 1;
        step(1);
        ia.reel_pulse = 0;
        check("r2_reel_score", 32'(ia.round_score), 1);
        wait_a_led(1'b1, k);
        check("r2_bite2_clks", 32'(k), 3);
        wait_a_led(1'b0, k);
        check("miss_window_clks", 32'(k), 8);
        check("miss_score", 32'(ia.round_score), 1);
        k = 0;
        while (ia.game_over !== 1'b1 && k < 60) begin
            step(1);
            k++;
        end
        check("r2_done", 32'(ia.game_over), 1);
        check("r2_final_score", 32'(ia.round_score), 1);

        // Round 3: logout during BITE beats a simultaneous reel
        ia.start_pulse = 1;
        step(1);
        ia.start_pulse = 0;
        wait_a_led(1'b1, k);
        check("r3_bite_clks", 32'(k), 4);
        ia.access_valid = 0; ia.reel_pulse = 1; ia.rand_val = 8'h03;
        step(1);
        ia.reel_pulse = 0;
        check("logout_state", 32'(ia.state_code), 0);
        check("logout_score", 32'(ia.round_score), 0);
        check("logout_led", 32'(ia.bite_led), 0);
        check("logout_time", 32'(ia.time_left), 0);
        step(30);
        check("wr_pulses", 32'(wr_cnt), 2);

        // Saturation on the long-round instance
        ib.access_valid = 1; ib.user_id = 5;
        step(1);
        ib.start_pulse = 1; ib.rand_val = 8'h00;
        step(1);
        ib.start_pulse = 0;
        exp_b = 0;
        for (int r = 0; r < 27; r++) begin
            wait_b_led(k);
            check("sat_bite_seen", 32'(ib.bite_led), 1);
            rb = (r == 24) ? 8'h01 : 8'h03;
            ib.reel_pulse = 1; ib.rand_val = rb;
            step(1);
            ib.reel_pulse = 0;
            exp_b = exp_b + 1 + int'(rb[1:0]);
            if (exp_b > SMAX) exp_b = SMAX;
            check("sat_score", 32'(ib.round_score), 32'(exp_b));
            if (r == 24) check("sat_preload_98", 32'(ib.round_score), 98);
            if (r == 25) check("sat_clamp_99", 32'(ib.round_score), 99);
        end
        check("sat_still_99", 32'(ib.round_score), 99);
        check("sat_no_wr", 32'(ib.score_wr_en), 0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
